// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types, defaults and byte-merge helper for the data-memory arbiter.
package dmem_pkg;
    typedef enum logic {ST_IDLE, ST_MERGE} state_t;

    localparam int MEM_AW_DEF = 8;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] strb);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = strb[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        return r;
    endfunction
endpackage

// File: rtl/dmem_rr_picker.sv
// dmem_rr_picker: two-way grant from request valids, round-robin or fixed priority.
module dmem_rr_picker #(
    parameter bit RR_ENABLE = 1'b1
) (
    input  logic i_v0,
    input  logic i_v1,
    input  logic i_last,
    output logic o_g0,
    output logic o_g1
);
    always_comb begin
        o_g0 = i_v0 & (~i_v1 | ~RR_ENABLE | i_last);
        o_g1 = i_v1 & ~o_g0;
    end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port word memory between two requesters,
// with one-cycle responses and read-modify-write for partial-strobe writes.
module dmem_arbiter import dmem_pkg::*; #(
    parameter int MEM_AW    = MEM_AW_DEF,
    parameter bit RR_ENABLE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_p0_req_valid,
    output logic        o_p0_req_ready,
    input  logic        i_p0_req_we,
    input  logic [31:0] i_p0_req_addr,
    input  logic [31:0] i_p0_req_wdata,
    input  logic [3:0]  i_p0_req_wstrb,
    output logic        o_p0_rsp_valid,
    output logic [31:0] o_p0_rsp_rdata,
    output logic        o_p0_rsp_err,
    input  logic        i_p1_req_valid,
    output logic        o_p1_req_ready,
    input  logic        i_p1_req_we,
    input  logic [31:0] i_p1_req_addr,
    input  logic [31:0] i_p1_req_wdata,
    input  logic [3:0]  i_p1_req_wstrb,
    output logic        o_p1_rsp_valid,
    output logic [31:0] o_p1_rsp_rdata,
    output logic        o_p1_rsp_err,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_write_data,
    output logic        o_mem_read,
    output logic        o_mem_write,
    input  logic [31:0] i_mem_read_data
);
    state_t            r_state;
    logic              r_last, r_port, r_rsp_err;
    logic [1:0]        r_rsp_v;
    logic [31:0]       r_rsp_rdata, r_old, r_wdata;
    logic [3:0]        r_strb;
    logic [MEM_AW-1:0] r_idx;
    logic              w_g0, w_g1, w_idle, w_merge, w_acc, w_sel, w_we, w_err, w_partial, w_rd, w_wr;
    logic [31:0]       w_addr, w_wdata;
    logic [3:0]        w_strb;
    logic [MEM_AW-1:0] w_idx;

    dmem_rr_picker #(.RR_ENABLE(RR_ENABLE)) u_picker (
        .i_v0   (i_p0_req_valid),
        .i_v1   (i_p1_req_valid),
        .i_last (r_last),
        .o_g0   (w_g0),
        .o_g1   (w_g1)
    );

    always_comb begin
        w_idle         = (r_state == ST_IDLE) && !rst;
        w_merge        = (r_state == ST_MERGE) && !rst;
        o_p0_req_ready = w_idle & w_g0;
        o_p1_req_ready = w_idle & w_g1;
        w_acc          = o_p0_req_ready | o_p1_req_ready;
        w_sel          = w_g1;
        w_we           = w_sel ? i_p1_req_we    : i_p0_req_we;
        w_addr         = w_sel ? i_p1_req_addr  : i_p0_req_addr;
        w_wdata        = w_sel ? i_p1_req_wdata : i_p0_req_wdata;
        w_strb         = w_sel ? i_p1_req_wstrb : i_p0_req_wstrb;
        w_err          = (|w_addr[1:0]) || (|w_addr[31:MEM_AW+2]);
        w_idx          = w_addr[MEM_AW+1:2];
        w_partial      = w_we && (w_strb != 4'hF) && (|w_strb);
        // Partial writes read the old word first; the write itself happens in MERGE.
        w_rd           = w_acc && !w_err && (!w_we || w_partial);
        w_wr           = (w_acc && !w_err && w_we && (w_strb == 4'hF)) || w_merge;
        o_mem_read     = w_rd;
        o_mem_write    = w_wr;
        o_mem_addr     = (w_rd || w_wr) ? {{(30-MEM_AW){1'b0}}, w_merge ? r_idx : w_idx, 2'b00} : '0;
        o_mem_write_data = !w_wr ? '0 : w_merge ? byte_merge(r_old, r_wdata, r_strb) : w_wdata;
        o_p0_rsp_valid = r_rsp_v[0];
        o_p1_rsp_valid = r_rsp_v[1];
        o_p0_rsp_rdata = r_rsp_v[0] ? r_rsp_rdata : '0;
        o_p1_rsp_rdata = r_rsp_v[1] ? r_rsp_rdata : '0;
        o_p0_rsp_err   = r_rsp_v[0] & r_rsp_err;
        o_p1_rsp_err   = r_rsp_v[1] & r_rsp_err;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_last      <= 1'b1;
            r_rsp_v     <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_v     <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            if (r_state == ST_MERGE) begin
                r_state          <= ST_IDLE;
                r_rsp_v[r_port]  <= 1'b1;
            end else if (w_acc) begin
                r_last <= w_sel;
                if (w_partial && !w_err) begin
                    r_state <= ST_MERGE;
                    r_old   <= i_mem_read_data;
                    r_idx   <= w_idx;
                    r_wdata <= w_wdata;
                    r_strb  <= w_strb;
                    r_port  <= w_sel;
                end else begin
                    r_rsp_v[w_sel] <= 1'b1;
                    r_rsp_err      <= w_err;
                    r_rsp_rdata    <= (w_we || w_err) ? '0 : i_mem_read_data;
                end
            end
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vectors plus hand-written multi-cycle sequences
// against a behavioural sync-write / comb-read memory.
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        p0_valid, p0_we, p1_valid, p1_we;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic [3:0]  p0_strb, p1_strb;
    logic        p0_ready, p1_ready, p0_rv, p1_rv, p0_err, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write;
    logic        f_p0_ready, f_p1_ready, f_p0_rv, f_p1_rv, f_p0_err, f_p1_err, f_mem_read, f_mem_write;
    logic [31:0] f_p0_rdata, f_p1_rdata, f_mem_addr, f_mem_wdata, f_mem_rdata;
    logic [31:0] mem [256];
    logic        poke_en = 1'b0;
    logic [7:0]  poke_idx = '0;
    logic [31:0] poke_data = '0;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (poke_en) mem[poke_idx] <= poke_data;
        else if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
    end
    assign mem_rdata   = mem[mem_addr[9:2]];
    assign f_mem_rdata = mem[f_mem_addr[9:2]];

    dmem_arbiter #(.MEM_AW(8), .RR_ENABLE(1'b1)) dut (
        .clk(clk), .rst(rst),
        .i_p0_req_valid(p0_valid), .o_p0_req_ready(p0_ready), .i_p0_req_we(p0_we),
        .i_p0_req_addr(p0_addr), .i_p0_req_wdata(p0_wdata), .i_p0_req_wstrb(p0_strb),
        .o_p0_rsp_valid(p0_rv), .o_p0_rsp_rdata(p0_rdata), .o_p0_rsp_err(p0_err),
        .i_p1_req_valid(p1_valid), .o_p1_req_ready(p1_ready), .i_p1_req_we(p1_we),
        .i_p1_req_addr(p1_addr), .i_p1_req_wdata(p1_wdata), .i_p1_req_wstrb(p1_strb),
        .o_p1_rsp_valid(p1_rv), .o_p1_rsp_rdata(p1_rdata), .o_p1_rsp_err(p1_err),
        .o_mem_addr(mem_addr), .o_mem_write_data(mem_wdata), .o_mem_read(mem_read),
        .o_mem_write(mem_write), .i_mem_read_data(mem_rdata)
    );

    dmem_arbiter #(.MEM_AW(8), .RR_ENABLE(1'b0)) dut_fixed (
        .clk(clk), .rst(rst),
        .i_p0_req_valid(p0_valid), .o_p0_req_ready(f_p0_ready), .i_p0_req_we(p0_we),
        .i_p0_req_addr(p0_addr), .i_p0_req_wdata(p0_wdata), .i_p0_req_wstrb(p0_strb),
        .o_p0_rsp_valid(f_p0_rv), .o_p0_rsp_rdata(f_p0_rdata), .o_p0_rsp_err(f_p0_err),
        .i_p1_req_valid(p1_valid), .o_p1_req_ready(f_p1_ready), .i_p1_req_we(p1_we),
        .i_p1_req_addr(p1_addr), .i_p1_req_wdata(p1_wdata), .i_p1_req_wstrb(p1_strb),
        .o_p1_rsp_valid(f_p1_rv), .o_p1_rsp_rdata(f_p1_rdata), .o_p1_rsp_err(f_p1_err),
        .o_mem_addr(f_mem_addr), .o_mem_write_data(f_mem_wdata), .o_mem_read(f_mem_read),
        .o_mem_write(f_mem_write), .i_mem_read_data(f_mem_rdata)
    );

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          lat;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic poke(input logic [7:0] idx, input logic [31:0] data);
        poke_en = 1'b1;
        poke_idx = idx;
        poke_data = data;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    task automatic set_req(input logic port, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb);
        if (port) begin
            p1_valid = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_strb = strb;
        end else begin
            p0_valid = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_strb = strb;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        p0_valid = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0; p0_strb = 0;
        p1_valid = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0; p1_strb = 0;
        vecs[0]  = '{1'b0, 1'b0, 32'h10,  32'h0,        4'h0, 1, 32'hDEADBEEF, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 32'h1C,  32'h0,        4'h0, 1, 32'h55667788, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 32'h6,   32'h0,        4'h0, 1, 32'h0,        1'b1};
        vecs[3]  = '{1'b0, 1'b0, 32'h400, 32'h0,        4'h0, 1, 32'h0,        1'b1};
        vecs[4]  = '{1'b1, 1'b1, 32'h20,  32'hCAFEF00D, 4'hF, 1, 32'h0,        1'b0};
        vecs[5]  = '{1'b0, 1'b0, 32'h20,  32'h0,        4'h0, 1, 32'hCAFEF00D, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 32'h1C,  32'hFFFFFFFF, 4'h0, 1, 32'h0,        1'b0};
        vecs[7]  = '{1'b1, 1'b0, 32'h1C,  32'h0,        4'h0, 1, 32'h55667788, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 32'h8,   32'hAABBCCDD, 4'h5, 2, 32'h0,        1'b0};
        vecs[9]  = '{1'b1, 1'b0, 32'h8,   32'h0,        4'h0, 1, 32'h11BB33DD, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 32'h3FC, 32'h12345678, 4'hF, 1, 32'h0,        1'b0};
        vecs[11] = '{1'b0, 1'b0, 32'h3FC, 32'h0,        4'h0, 1, 32'h12345678, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 32'h21,  32'h99999999, 4'hF, 1, 32'h0,        1'b1};
        vecs[13] = '{1'b1, 1'b0, 32'h20,  32'h0,        4'h0, 1, 32'hCAFEF00D, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 32'h0,   32'hA0B0C0D0, 4'h8, 2, 32'h0,        1'b0};
        vecs[15] = '{1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1, 32'hA0020304, 1'b0};

        @(negedge clk);
        poke(8'd4, 32'hDEADBEEF);
        poke(8'd7, 32'h55667788);
        poke(8'd2, 32'h11223344);
        poke(8'd0, 32'h01020304);
        poke(8'd9, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Reset state with no traffic
        chk("reset_ready", {30'b0, p0_ready, p1_ready}, 32'h0);
        chk("reset_rsp_valid", {30'b0, p0_rv, p1_rv}, 32'h0);
        chk("reset_mem_ctl", {30'b0, mem_read, mem_write}, 32'h0);
        chk("reset_rdata", p0_rdata | p1_rdata, 32'h0);

        foreach (vecs[i]) begin
            set_req(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].strb);
            #1;
            chk($sformatf("v%0d_ready", i), {31'b0, vecs[i].port ? p1_ready : p0_ready}, 32'h1);
            if (vecs[i].err) chk($sformatf("v%0d_no_mem", i), {30'b0, mem_read, mem_write}, 32'h0);
            @(negedge clk);
            p0_valid = 1'b0;
            p1_valid = 1'b0;
            if (vecs[i].lat == 2) begin
                chk($sformatf("v%0d_early_rsp", i), {30'b0, p0_rv, p1_rv}, 32'h0);
                @(negedge clk);
            end
            chk($sformatf("v%0d_rsp_valid", i), {30'b0, p0_rv, p1_rv}, vecs[i].port ? 32'h1 : 32'h2);
            chk($sformatf("v%0d_rdata", i), vecs[i].port ? p1_rdata : p0_rdata, vecs[i].rdata);
            chk($sformatf("v%0d_err", i), {31'b0, vecs[i].port ? p1_err : p0_err}, {31'b0, vecs[i].err});
        end

        // Contention: RR alternates starting with p0, fixed priority always p0
        do_reset();
        set_req(1'b0, 1'b0, 32'h10, 32'h0, 4'h0);
        set_req(1'b1, 1'b0, 32'h1C, 32'h0, 4'h0);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("rr_grant%0d", k), {30'b0, p0_ready, p1_ready}, (k % 2 == 0) ? 32'h2 : 32'h1);
            chk($sformatf("fixed_grant%0d", k), {30'b0, f_p0_ready, f_p1_ready}, 32'h2);
            if (k > 0) chk($sformatf("rr_rsp%0d", k), (k % 2 == 1) ? p0_rdata : p1_rdata,
                           (k % 2 == 1) ? 32'hDEADBEEF : 32'h55667788);
            @(negedge clk);
        end
        p0_valid = 1'b0;
        p1_valid = 1'b0;
        chk("rr_last_rsp", {30'b0, p0_rv, p1_rv}, 32'h1);
        chk("rr_last_rdata", p1_rdata, 32'h55667788);

        // Partial write from p1 while p0 waits through the MERGE cycle
        poke(8'd2, 32'h11223344);
        set_req(1'b1, 1'b1, 32'h8, 32'hAABBCCDD, 4'b0101);
        #1;
        chk("merge_p1_ready", {31'b0, p1_ready}, 32'h1);
        chk("merge_rd_phase", {30'b0, mem_read, mem_write}, 32'h2);
        @(negedge clk);
        p1_valid = 1'b0;
        set_req(1'b0, 1'b0, 32'h8, 32'h0, 4'h0);
        #1;
        chk("merge_p0_blocked", {31'b0, p0_ready}, 32'h0);
        chk("merge_wr_phase", {30'b0, mem_read, mem_write}, 32'h1);
        chk("merge_wdata", mem_wdata, 32'h11BB33DD);
        chk("merge_waddr", mem_addr, 32'h8);
        @(negedge clk);
        chk("merge_p1_rsp", {30'b0, p0_rv, p1_rv}, 32'h1);
        chk("merge_p0_granted", {31'b0, p0_ready}, 32'h1);
        @(negedge clk);
        p0_valid = 1'b0;
        chk("merge_p0_rsp", {30'b0, p0_rv, p1_rv}, 32'h2);
        chk("merge_readback", p0_rdata, 32'h11BB33DD);

        // Reset during MERGE drops the pending write and its response
        poke(8'd2, 32'h11223344);
        set_req(1'b0, 1'b1, 32'h8, 32'hFFFFFFFF, 4'b0011);
        @(negedge clk);
        p0_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rstmerge_no_write", {31'b0, mem_write}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        chk("rstmerge_no_rsp", {30'b0, p0_rv, p1_rv}, 32'h0);
        @(negedge clk);
        chk("rstmerge_no_rsp2", {30'b0, p0_rv, p1_rv}, 32'h0);
        chk("rstmerge_word", mem[2], 32'h11223344);

        // Full write followed immediately by a read of the same word
        set_req(1'b0, 1'b1, 32'h24, 32'hCAFEF00D, 4'hF);
        @(negedge clk);
        chk("b2b_wr_ack", {30'b0, p0_rv, p1_rv}, 32'h2);
        set_req(1'b0, 1'b0, 32'h24, 32'h0, 4'h0);
        #1;
        chk("b2b_rd_ready", {31'b0, p0_ready}, 32'h1);
        @(negedge clk);
        p0_valid = 1'b0;
        chk("b2b_rd_rsp", {30'b0, p0_rv, p1_rv}, 32'h2);
        chk("b2b_rd_data", p0_rdata, 32'hCAFEF00D);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
